// File: rtl/jts16_obj_pkg.sv
// Shared types and word helpers for the jts16 object line buffer.
// Helpers work on 32-bit words so any DW up to 32 can use them.
package jts16_obj_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  function automatic logic [31:0] fill_word(
    input int alpha,
    input int alpha_w
  );
    logic [31:0] m;
    m = (32'd1 << alpha_w) - 32'd1;
    return 32'(alpha) & m;
  endfunction

  function automatic logic [31:0] prio_field(
    input logic [31:0] w,
    input int          lsb,
    input int          pw
  );
    return (w >> lsb) & ((32'd1 << pw) - 32'd1);
  endfunction

  function automatic logic is_transp(
    input logic [31:0] w,
    input int          alpha_w,
    input int          alpha
  );
    logic [31:0] m;
    m = (32'd1 << alpha_w) - 32'd1;
    return (w & m) == (32'(alpha) & m);
  endfunction

endpackage

// File: rtl/jts16_obj_lbuf_bank.sv
// One line bank: simple dual-port RAM, one write port and
// one registered read port.
module jts16_obj_lbuf_bank #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:2**AW-1];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/jts16_obj_lbuf.sv
// Double-banked object line buffer: priority RMW draw port,
// flip-aware scan-out with erase-behind and power-on clear.
module jts16_obj_lbuf
  import jts16_obj_pkg::*;
#(
  parameter int DW       = 12,
  parameter int AW       = 9,
  parameter int ALPHA_W  = 4,
  parameter int ALPHA    = 0,
  parameter int PRIO_EN  = 1,
  parameter int PRIO_LSB = 10,
  parameter int PRIO_W   = 2,
  parameter int HSTART   = 'ha2,
  parameter int HFLIP    = 'h1e
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          flip,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] wr_addr,
  input  logic          we,
  output logic [DW-1:0] pxl,
  output logic          ready
);

  localparam int N = 2**AW;
  localparam logic [31:0] FILL32 = fill_word(ALPHA, ALPHA_W);
  localparam logic [DW-1:0] FILL = FILL32[DW-1:0];
  localparam int HF_I = (N - 1 + HFLIP) % N;
  localparam int HS_I = HSTART % N;
  localparam logic [AW-1:0] HLOAD_F = HF_I[AW-1:0];
  localparam logic [AW-1:0] HLOAD_N = HS_I[AW-1:0];

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;
  logic          wsel_q, wsel_d;
  logic          lhbl_q;
  logic [AW-1:0] hobj_q, hobj_d;
  logic [DW-1:0] pxl_q, pxl_d;
  logic          s1_v_q, s1_v_d;
  logic [AW-1:0] s1_addr_q;
  logic [DW-1:0] s1_data_q;
  logic          s1_bank_q;
  logic [31:0]   s1_prio_q, s1_prio_d;
  logic          fwd_v_q, fwd_v_d;
  logic [DW-1:0] fwd_data_q;
  logic          scan_v_q, scan_v_d;
  logic [AW-1:0] scan_addr_q;
  logic          scan_bank_q;
  logic [DW-1:0] stored;
  logic          win;
  logic [DW-1:0] rd  [2];
  logic          bwe [2];
  logic [AW-1:0] bwa [2];
  logic [AW-1:0] bra [2];
  logic [DW-1:0] bwd [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (&cnt_q) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: ready_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    stored = fwd_v_q ? fwd_data_q : rd[s1_bank_q];
    win = s1_v_q
      && !is_transp(32'(s1_data_q), ALPHA_W, ALPHA)
      && (is_transp(32'(stored), ALPHA_W, ALPHA)
          || (PRIO_EN == 0)
          || (s1_prio_q >=
              prio_field(32'(stored), PRIO_LSB, PRIO_W)));
    s1_v_d    = we && (state_q == RUN);
    s1_prio_d = prio_field(32'(wr_data), PRIO_LSB, PRIO_W);
    // RAM reads old data on a same-edge write; bypass it
    fwd_v_d = win && s1_v_d
      && (s1_bank_q == wsel_q)
      && (s1_addr_q == wr_addr);
    wsel_d = wsel_q ^ (lhbl_q & ~LHBL);
    hobj_d = hobj_q;
    if (!LHBL)
      hobj_d = flip ? HLOAD_F : HLOAD_N;
    else if (pxl_cen)
      hobj_d = flip ? hobj_q - AW'(1) : hobj_q + AW'(1);
    scan_v_d = pxl_cen && (state_q == RUN);
    pxl_d = pxl_q;
    if (state_q == CLEAR)
      pxl_d = FILL;
    else if (scan_v_q)
      pxl_d = rd[scan_bank_q];
    for (int b = 0; b < 2; b++) begin
      bwe[b] = 1'b0;
      bwa[b] = cnt_q;
      bwd[b] = FILL;
      bra[b] = (b[0] == wsel_q) ? wr_addr : hobj_q;
      if (state_q == CLEAR) begin
        bwe[b] = 1'b1;
      end else if (win && (s1_bank_q == b[0])) begin
        bwe[b] = 1'b1;
        bwa[b] = s1_addr_q;
        bwd[b] = s1_data_q;
      end else if (scan_v_q && (scan_bank_q == b[0])) begin
        bwe[b] = 1'b1;
        bwa[b] = scan_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wsel_q      <= 1'b0;
      lhbl_q      <= 1'b0;
      hobj_q      <= HLOAD_N;
      pxl_q       <= FILL;
      s1_v_q      <= 1'b0;
      s1_addr_q   <= '0;
      s1_data_q   <= FILL;
      s1_bank_q   <= 1'b0;
      s1_prio_q   <= '0;
      fwd_v_q     <= 1'b0;
      fwd_data_q  <= FILL;
      scan_v_q    <= 1'b0;
      scan_addr_q <= '0;
      scan_bank_q <= 1'b0;
    end else begin
      wsel_q      <= wsel_d;
      lhbl_q      <= LHBL;
      hobj_q      <= hobj_d;
      pxl_q       <= pxl_d;
      s1_v_q      <= s1_v_d;
      s1_addr_q   <= wr_addr;
      s1_data_q   <= wr_data;
      s1_bank_q   <= wsel_q;
      s1_prio_q   <= s1_prio_d;
      fwd_v_q     <= fwd_v_d;
      fwd_data_q  <= s1_data_q;
      scan_v_q    <= scan_v_d;
      scan_addr_q <= hobj_q;
      scan_bank_q <= ~wsel_q;
    end
  end

  jts16_obj_lbuf_bank #(.DW(DW), .AW(AW)) u_bank0 (
    .clk     (clk),
    .we_i    (bwe[0]),
    .waddr_i (bwa[0]),
    .wdata_i (bwd[0]),
    .raddr_i (bra[0]),
    .rdata_o (rd[0])
  );

  jts16_obj_lbuf_bank #(.DW(DW), .AW(AW)) u_bank1 (
    .clk     (clk),
    .we_i    (bwe[1]),
    .waddr_i (bwa[1]),
    .wdata_i (bwd[1]),
    .raddr_i (bra[1]),
    .rdata_o (rd[1])
  );

  assign pxl   = pxl_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_jts16_obj_lbuf.sv
// Bench for jts16_obj_lbuf: line-level model of both banks
// checked every cycle, plus hand-computed scan-out values.
module tb_jts16_obj_lbuf;

  localparam int DW = 12;
  localparam int AW = 9;
  localparam int N  = 512;
  localparam logic [8:0] HST = 9'h0a2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pxl_cen;
  logic          LHBL;
  logic          flip;
  logic          we;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] pxl;
  logic          ready;

  always #5 clk = ~clk;

  jts16_obj_lbuf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .LHBL    (LHBL),
    .flip    (flip),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .we      (we),
    .pxl     (pxl),
    .ready   (ready)
  );

  int n_run = 0;
  int n_fail = 0;

  // model state
  logic [DW-1:0] mb [2][N];
  int         clr_n = 0;
  bit         m_seen = 0;
  bit         m_wsel;
  logic [8:0] m_hobj;
  logic [11:0] m_pxl, m_pend;
  bit         m_pend_v, m_new, m_lprev, m_ready;
  int         m_cnt, m_pidx, m_idx;

  // literal expectations on the scanned-out line
  logic [11:0] line_vals [N];
  int          lit_idx [32];
  logic [11:0] lit_val [32];
  int          lit_n = 0;
  int          lit_k = 0;

  task automatic model_write(input bit b, input logic [8:0] a,
                             input logic [11:0] d);
    logic [11:0] s;
    s = mb[b][a];
    if (d[3:0] == 4'h0) return;
    if (s[3:0] == 4'h0 || d[11:10] >= s[11:10]) mb[b][a] = d;
  endtask

  task automatic model_step();
    m_seen = 1;
    m_new  = 0;
    if (!rst_n) begin
      clr_n = 0; m_wsel = 0; m_hobj = HST; m_pxl = 12'h000;
      m_pend_v = 0; m_lprev = 0; m_cnt = 0;
    end else begin
      if (clr_n < N) begin
        mb[0][clr_n] = 12'h000;
        mb[1][clr_n] = 12'h000;
        clr_n++;
      end else begin
        if (we) model_write(m_wsel, wr_addr, wr_data);
        if (m_pend_v) begin
          m_pxl = m_pend; m_idx = m_pidx; m_new = 1; m_pend_v = 0;
        end
        if (pxl_cen) begin
          m_pend = mb[!m_wsel][m_hobj];
          mb[!m_wsel][m_hobj] = 12'h000;
          m_pend_v = 1; m_pidx = m_cnt; m_cnt++;
        end
      end
      if (!LHBL) begin
        m_hobj = flip ? 9'((N - 1 + 30) % N) : HST;
        m_cnt = 0;
      end else if (pxl_cen) begin
        m_hobj = flip ? m_hobj - 9'd1 : m_hobj + 9'd1;
      end
      if (m_lprev && !LHBL) m_wsel = !m_wsel;
      m_lprev = LHBL;
    end
    m_ready = (clr_n == N);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_seen) begin
      n_run++;
      if (ready !== m_ready) begin
        n_fail++;
        $display("FAIL ready t=%0t: got %b want %b",
                 $time, ready, m_ready);
      end
      n_run++;
      if (pxl !== m_pxl) begin
        n_fail++;
        $display("FAIL pxl t=%0t: got %h want %h",
                 $time, pxl, m_pxl);
      end
      if (m_new && m_idx < N) line_vals[m_idx] = pxl;
    end
    while (lit_k < lit_n) begin
      n_run++;
      if (line_vals[lit_idx[lit_k]] !== lit_val[lit_k]) begin
        n_fail++;
        $display("FAIL lit%0d idx=%0d: got %h want %h", lit_k,
                 lit_idx[lit_k], line_vals[lit_idx[lit_k]],
                 lit_val[lit_k]);
      end
      lit_k++;
    end
  end

  function automatic int nidx(input logic [8:0] a);
    logic [8:0] t;
    t = a - HST;
    return int'(t);
  endfunction

  function automatic int fidx(input logic [8:0] a);
    logic [8:0] t;
    t = 9'h01d - a;
    return int'(t);
  endfunction

  task automatic expect_lit(input int idx, input logic [11:0] v);
    lit_idx[lit_n] = idx;
    lit_val[lit_n] = v;
    lit_n++;
  endtask

  task automatic wr(input logic [8:0] a, input logic [11:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  // blank, one full active line, then the swap into blanking
  task automatic line(input logic f, input logic edge_wr);
    flip = f; LHBL = 1'b0;
    repeat (3) @(negedge clk);
    LHBL = 1'b1;
    for (int i = 0; i < N; i++) begin
      pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      if (edge_wr && i == N - 1) begin
        we = 1'b1; wr_addr = 9'h070; wr_data = 12'h40d;
      end
      @(negedge clk);
    end
    LHBL = 1'b0;
    if (edge_wr) begin
      wr_addr = 9'h071; wr_data = 12'h40e;
    end
    @(negedge clk);
    we = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b0; flip = 1'b0;
    we = 1'b0; wr_data = '0; wr_addr = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);

    line(1'b0, 1'b0);
    line(1'b0, 1'b0);

    wr(9'h040, 12'h405); wr(9'h040, 12'h007); idle();
    wr(9'h042, 12'h007); wr(9'h042, 12'h405); idle();
    wr(9'h041, 12'h007); wr(9'h041, 12'h405); idle();
    wr(9'h041, 12'h409); idle();
    wr(9'h050, 12'h321); idle();
    wr(9'h050, 12'h7f0); idle();
    wr(9'h060, 12'h401); wr(9'h060, 12'h802);
    wr(9'h060, 12'h403); idle();
    wr(9'h1ff, 12'h0a1); wr(9'h000, 12'h0b2);
    wr(9'h0a2, 12'h0c3); idle();

    line(1'b0, 1'b0);
    line(1'b0, 1'b0);
    expect_lit(nidx(9'h040), 12'h405);
    expect_lit(nidx(9'h042), 12'h405);
    expect_lit(nidx(9'h041), 12'h409);
    expect_lit(nidx(9'h050), 12'h321);
    expect_lit(nidx(9'h060), 12'h802);
    expect_lit(0, 12'h0c3);
    expect_lit(9'h15d, 12'h0a1);
    expect_lit(9'h15e, 12'h0b2);

    wr(9'h01d, 12'h40a); wr(9'h01c, 12'h40b);
    wr(9'h01e, 12'h40c); idle();
    line(1'b0, 1'b0);
    line(1'b1, 1'b1);
    expect_lit(0, 12'h40a);
    expect_lit(1, 12'h40b);
    expect_lit(511, 12'h40c);
    expect_lit(fidx(9'h040), 12'h000);
    expect_lit(fidx(9'h060), 12'h000);

    line(1'b0, 1'b0);
    expect_lit(nidx(9'h070), 12'h40d);
    expect_lit(nidx(9'h071), 12'h40e);

    repeat (3) @(negedge clk);
    if (lit_k != lit_n) begin
      $display("FAIL lit_drain: got %0d want %0d", lit_k, lit_n);
      $fatal(1, "literal checks not drained");
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/jts16_obj_lbuf.md
# jts16_obj_lbuf

Parametrised double-banked sprite line buffer for the object pipeline. It sits between the object draw engine and the colour mixer. While the draw engine fills one bank for the next line, the other bank is scanned out at pixel rate and erased behind the read pointer. It generalises the plain ping-pong buffer in three ways: configurable widths, priority-aware read-modify-write with transparency rejection, and a built-in flip-aware horizontal read counter plus power-on clear sequencer.

## Interface
Parameters:
- `DW`, 12: pixel word width.
- `AW`, 9: line address width; each bank holds 2^AW words.
- `ALPHA_W`, 4: width of the transparency field, bits [ALPHA_W-1:0].
- `ALPHA`, 0: transparent code. FILL = ALPHA zero-extended to DW.
- `PRIO_EN`, 1: enables the priority compare.
- `PRIO_LSB`, 10: LSB of the priority field.
- `PRIO_W`, 2: width of the priority field.
- `HSTART`, 9'ha2: read counter load value when not flipped.
- `HFLIP`, 9'h1e: offset added to 2^AW-1 to form the flipped load value.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `pxl_cen` in 1: pixel clock enable.
- `LHBL` in 1: horizontal blank, active-low.
- `flip` in 1: screen flip; the read counter counts down when set.
- `wr_data` in DW: pixel from the draw engine.
- `wr_addr` in AW: x position of the pixel.
- `we` in 1: write strobe; one pixel per cycle maximum.
- `pxl` out DW: scanned-out pixel.
- `ready` out 1: high once the clear sweep has finished.

## Operation
- Two banks. `wsel` selects the draw bank; the read bank is `!wsel`.
- `wsel` toggles on every LHBL falling edge (start of blanking).
- Each bank is 1R1W. The role mux assigns the ports:
  - draw bank: RMW read and RMW write;
  - read bank: scan read and erase write.
- Write pipeline:
  - S1 registers addr, data, bank and priority, and issues the read.
  - S2 compares against the stored word and writes the winner.
- Write rules, in order:
  - incoming transparent (low ALPHA_W bits == ALPHA): dropped;
  - stored word transparent: write;
  - PRIO_EN=0: write;
  - otherwise write iff new prio >= stored prio.
- Forwarding: if S2 writes the same bank and address that S1 reads in the same cycle, S1 uses the S2 data.
- The bank id is captured in S1. A write in flight across a swap completes into its original bank.
- Read counter `hobj` (AW bits):
  - while LHBL=0: loads HSTART, or 2^AW-1+HFLIP when flip=1;
  - while LHBL=1 and pxl_cen=1: steps +1, or -1 when flip=1;
  - wraps modulo 2^AW.
- Scan: on pxl_cen, reads the read bank at `hobj`. The following cycle it registers `pxl` and writes FILL to that address (erase).
- Clear FSM states:
  - CLEAR: a counter sweeps 0..2^AW-1, writing FILL to both banks each cycle. `we` is ignored, `pxl` is held at FILL, `ready`=0.
  - RUN: normal operation. It is entered after the last address is written.

## Timing
- On reset (rst_n low at a clock edge): state=CLEAR, sweep counter=0, wsel=0, hobj=HSTART, pxl=FILL, ready=0, S1/S2 invalid.
- Reset mid-line or mid-sweep restarts the sweep from 0.
- `ready` rises 2^AW cycles after rst_n is sampled high (512 for AW=9).
- Write latency: 2 cycles from `we` to the RAM update. Throughput: 1 pixel per clk.
- Read latency: `pxl` is valid 1 clk after the pxl_cen cycle and holds until the next pxl_cen.
- Erase lands 1 clk after the read, before the next pxl_cen. pxl_cen is never on consecutive clks.
- LHBL falling edge and `we` in the same cycle: the write goes to the old draw bank. The pixel lands in the line just swapped to scan-out. The draw engine avoids this by finishing before blanking.
- Writes with LHBL=0 are legal; the draw normally runs during the whole line.

## Structure
- Shared package `jts16_obj_pkg` holds:
  - the FILL function;
  - the prio-field extract function;
  - the transparent-test function;
  - the state enum {CLEAR, RUN}.
- One sub-module, `jts16_obj_lbuf_bank`: AWxDW simple dual-port RAM with registered read. It is instantiated twice; all muxing stays in the top.

## Test plan
- Reset, then idle: `ready`=0 for 512 clks, then 1. Reading every address of both banks returns 12'h000.
- Write addr 0x40 data 12'h405 (prio 1), then 12'h007 (prio 0), back to back. After the swap, the scan at hobj=0x40 gives 12'h405. Swap the order: 12'h405 still wins. A prio 1 write of 12'h409 then overwrites it.
- Write 12'h7F0 (transparent) to 0x50: dropped, and the stored word is unchanged.
- Same-address back-to-back writes to 0x60 of 12'h401, then 12'h802 (prio 2): forwarding gives 12'h802. A third write of 12'h403 (prio 1) is rejected.
- flip=1: the first pxl_cen after LHBL rises reads address 0x1FF+0x1E (mod 512) and the counter decrements. flip=0: starts at 0xA2 and increments. The 0x1FF→0x000 wrap is checked.
- After scan-out, a second swap leaves all scanned addresses at 12'h000. A write in S1 when LHBL falls completes into the original bank.
